// File: rtl/phy_rx_pkg.sv
// Shared definitions for the phy_rx receive path: alignment character,
// serial-to-parallel FSM state encoding and bit-counter width.
package phy_rx_pkg;

  localparam logic [7:0] BC_BYTE   = 8'hBC;
  localparam int         BIT_CNT_W = 3;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } sp_state_t;

endpackage

// File: rtl/phy_rx_sp_shift.sv
// Serial input shifter: exposes the byte window that includes the bit being
// sampled on the current edge (MSB-first arrival).
module phy_rx_sp_shift (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] sr_next
);

  // The oldest bit of the 8-bit window drops out of sr_next, so only the
  // seven most recent bits need to be stored.
  logic [6:0] sr;

  assign sr_next = {sr, data_in};

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      sr <= '0;
    end else begin
      sr <= sr_next[6:0];
    end
  end

endmodule

// File: rtl/phy_rx_serial_paralelo.sv
// phy_rx front stage: finds byte alignment on the 0xBC idle/COM character and
// forwards each aligned byte, held for 8 bit clocks. Optional BC counter output
// bc_seen is built when PHY_RX_SP_BCCOUNT_EN is defined.
module phy_rx_serial_paralelo #(
  parameter logic [7:0]  BC_BYTE   = phy_rx_pkg::BC_BYTE,
  parameter int unsigned BC_NEEDED = 4
) (
  input  logic       clk_32f,
  input  logic       reset_L,
  input  logic       data_in,
  output logic [7:0] data_000,
  output logic       valid_000,
  output logic       active
`ifdef PHY_RX_SP_BCCOUNT_EN
  ,
  output logic [7:0] bc_seen
`endif
);

  import phy_rx_pkg::*;

  localparam logic [3:0] BC_NEEDED_C = 4'(BC_NEEDED);

  sp_state_t              state, state_next;
  logic [BIT_CNT_W-1:0]   bit_cnt, bit_cnt_next;
  logic [3:0]             bc_cnt, bc_cnt_next;
  logic [7:0]             sr_next;
  logic [7:0]             data_next;
  logic                   valid_next;
  logic                   active_next;
  logic                   is_bc;
  logic                   boundary;
`ifdef PHY_RX_SP_BCCOUNT_EN
  logic [7:0]             bc_seen_next;
`endif

  phy_rx_sp_shift u_shift (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .data_in (data_in),
    .sr_next (sr_next)
  );

  assign is_bc    = (sr_next == BC_BYTE);
  assign boundary = (state != SEARCH) && (bit_cnt == '1);

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt + BIT_CNT_W'(1);
    bc_cnt_next  = bc_cnt;
    data_next    = data_000;
    valid_next   = valid_000;
    active_next  = active;
`ifdef PHY_RX_SP_BCCOUNT_EN
    bc_seen_next = bc_seen;
`endif
    case (state)
      SEARCH: begin
        if (is_bc) begin
          bit_cnt_next = '0;
          bc_cnt_next  = 4'd1;
          if (BC_NEEDED_C == 4'd1) begin
            state_next  = ACTIVE;
            active_next = 1'b1;
          end else begin
            state_next = LOCK;
          end
        end
      end
      LOCK: begin
        // A non-BC boundary byte drops straight back to hunting; it is not rescanned.
        if (boundary) begin
          if (is_bc) begin
            bc_cnt_next = bc_cnt + 4'd1;
            if (bc_cnt + 4'd1 == BC_NEEDED_C) begin
              state_next  = ACTIVE;
              active_next = 1'b1;
            end
          end else begin
            state_next  = SEARCH;
            bc_cnt_next = '0;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          data_next  = sr_next;
          valid_next = !is_bc;
`ifdef PHY_RX_SP_BCCOUNT_EN
          if (is_bc && (bc_seen != 8'hFF)) begin
            bc_seen_next = bc_seen + 8'd1;
          end
`endif
        end
      end
      default: begin
        state_next = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state     <= SEARCH;
      bit_cnt   <= '0;
      bc_cnt    <= '0;
      data_000  <= 8'h00;
      valid_000 <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_cnt_next;
      bc_cnt    <= bc_cnt_next;
      data_000  <= data_next;
      valid_000 <= valid_next;
      active    <= active_next;
    end
  end

`ifdef PHY_RX_SP_BCCOUNT_EN
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bc_seen <= 8'h00;
    end else begin
      bc_seen <= bc_seen_next;
    end
  end
`endif

endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// Scoreboard bench for phy_rx_serial_paralelo: every output change is matched
// against an expected {active, valid, data} tuple and the cycle it must occur on.
module tb_phy_rx_serial_paralelo;

  logic       clk_32f = 1'b0;
  logic       reset_L = 1'b0;
  logic       data_in = 1'b0;
  logic [7:0] data_000;
  logic       valid_000;
  logic       active;
`ifdef PHY_RX_SP_BCCOUNT_EN
  logic [7:0] bc_seen;
`endif

  phy_rx_serial_paralelo dut (
    .clk_32f   (clk_32f),
    .reset_L   (reset_L),
    .data_in   (data_in),
    .data_000  (data_000),
    .valid_000 (valid_000),
    .active    (active)
`ifdef PHY_RX_SP_BCCOUNT_EN
    ,
    .bc_seen   (bc_seen)
`endif
  );

  always #5 clk_32f = ~clk_32f;

  int cyc = 0;
  always @(posedge clk_32f) cyc++;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [9:0] val;
  } exp_t;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any change of the output tuple outside reset is a DUT event.
  logic [9:0] prev;
  logic [9:0] cur;
  exp_t       e;
  always @(negedge clk_32f) begin
    cur = {active, valid_000, data_000};
    if (!reset_L) begin
      prev = cur;
    end else if (cur !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got %h at cycle %0d, none expected", cur, cyc);
      end else begin
        e = q.pop_front();
        if (cur !== e.val || cyc != e.cyc) begin
          errors++;
          $display("FAIL out_change: got %h at cycle %0d expected %h at cycle %0d",
                   cur, cyc, e.val, e.cyc);
        end
      end
      prev = cur;
    end
  end

  task automatic send_bit(input logic b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  // Sends a byte MSB first; when chg is set, the tuple ev must appear on the
  // edge sampling the LSB.
  task automatic send_byte(input logic [7:0] b, input bit chg, input logic [9:0] ev);
    exp_t x;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    if (chg) begin
      x.cyc = cyc;
      x.val = ev;
      q.push_back(x);
    end
  endtask

  logic [7:0] stream_b [6] = '{8'hA5, 8'hBC, 8'h5A, 8'hA5, 8'hBC, 8'h5A};
  logic [9:0] stream_e [6] = '{10'h3A5, 10'h2BC, 10'h35A, 10'h3A5, 10'h2BC, 10'h35A};

  initial begin
    // Reset with random line activity.
    reset_L = 1'b0;
    repeat (3) begin
      @(negedge clk_32f);
      data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
    end
    #1;
    check("reset_data", data_000, 8'h00);
    check("reset_valid", valid_000, 1'b0);
    check("reset_active", active, 1'b0);
    @(negedge clk_32f);
    data_in = 1'b0;
    reset_L = 1'b1;

    // Three BCs then a bad boundary byte: lock is lost, link stays down.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (3) send_byte(8'hBC, 1'b0, 10'h0);
    send_byte(8'h3C, 1'b0, 10'h0);
    check("lock_fail_active", active, 1'b0);
    repeat (3) send_byte(8'hBC, 1'b0, 10'h0);
    send_byte(8'hBC, 1'b1, 10'h200);
    check("align_active", active, 1'b1);

    // Data stream while active.
    for (int i = 0; i < 6; i++) send_byte(stream_b[i], 1'b1, stream_e[i]);

    // Reset mid-byte while active.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    #1;
    reset_L = 1'b0;
    #1;
    check("async_rst_data", data_000, 8'h00);
    check("async_rst_valid", valid_000, 1'b0);
    check("async_rst_active", active, 1'b0);
    repeat (2) @(negedge clk_32f);
    data_in = 1'b0;
    reset_L = 1'b1;

    // Re-alignment needs four fresh BCs.
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    repeat (3) send_byte(8'hBC, 1'b0, 10'h0);
    check("realign_3bc_active", active, 1'b0);
    send_byte(8'hBC, 1'b1, 10'h200);
    send_byte(8'hA5, 1'b1, 10'h3A5);

    // Long BC run while active.
    send_byte(8'h5A, 1'b1, 10'h35A);
    send_byte(8'hBC, 1'b1, 10'h2BC);
    send_byte(8'hBC, 1'b0, 10'h0);
`ifdef PHY_RX_SP_BCCOUNT_EN
    check("bc_seen_2", bc_seen, 8'd2);
`endif
    repeat (298) send_byte(8'hBC, 1'b0, 10'h0);
`ifdef PHY_RX_SP_BCCOUNT_EN
    check("bc_seen_sat", bc_seen, 8'hFF);
`endif
    send_byte(8'hA5, 1'b1, 10'h3A5);

    repeat (3) @(negedge clk_32f);
    #1;
    check("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
